// File: rtl/seq_pkg.sv
// Shared types for the word-level "101" scan controller.
//   scan_state_e : controller FSM encoding (IDLE=0, SHIFT=1, DONE=2)
//   det_state_e  : serial detector encoding (idle / seen "1" / seen "10")
//   det_next()   : detector next-state rule; `overlap` selects whether a hit
//                  may reuse its final '1' as the start of the next match.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } scan_state_e;

  typedef enum logic [1:0] {
    DET_IDLE = 2'd0,
    DET_S1   = 2'd1,
    DET_S10  = 2'd2
  } det_state_e;

  function automatic det_state_e det_next(det_state_e s, logic i, logic overlap);
    det_state_e n;
    n = DET_IDLE;
    case (s)
      DET_IDLE: n = i ? DET_S1 : DET_IDLE;
      DET_S1:   n = i ? DET_S1 : DET_S10;
      DET_S10:  n = i ? (overlap ? DET_S1 : DET_IDLE) : DET_IDLE;
      default:  n = DET_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Word handshake and result bundle for seq_scan_ctrl.
//   master : word source / result consumer (drives in_valid, in_data, in_chain)
//   slave  : the controller (drives in_ready, busy, bit_out, hit, done,
//            match_cnt, ovf)
interface seq_scan_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_chain;
  logic             in_ready;
  logic             busy;
  logic             bit_out;
  logic             hit;
  logic             done;
  logic [CNT_W-1:0] match_cnt;
  logic             ovf;

  modport master (
    output in_valid, in_data, in_chain,
    input  in_ready, busy, bit_out, hit, done, match_cnt, ovf
  );

  modport slave (
    input  in_valid, in_data, in_chain,
    output in_ready, busy, bit_out, hit, done, match_cnt, ovf
  );
endinterface

// File: rtl/seq_det_101.sv
// Registered Mealy "101" detector that advances one bit per enabled cycle.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear to idle with q=0 (wins over en)
//   en       : step the detector with input bit i
//   i        : serial input bit
//   q        : registered match flag for the last stepped bit; held when idle
module seq_det_101
  import seq_pkg::*;
#(
  parameter int unsigned OVERLAP = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic i,
  output logic q
);

  det_state_e st_q, st_d;
  logic       q_q, q_d;

  always_comb begin
    st_d = st_q;
    q_d  = q_q;
    if (clr) begin
      st_d = DET_IDLE;
      q_d  = 1'b0;
    end else if (en) begin
      st_d = det_next(st_q, i, OVERLAP != 0);
      q_d  = (st_q == DET_S10) && i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= DET_IDLE;
      q_q  <= 1'b0;
    end else begin
      st_q <= st_d;
      q_q  <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-level scan controller: accepts a word, feeds it MSB-first into the
// "101" detector, counts current-word hits and reports them with `done`.
//   clk, rst : clock, synchronous active-high reset
//   bus      : seq_scan_ctrl_if.slave (in_valid/in_data/in_chain handshake in,
//              in_ready/busy/bit_out/hit/done/match_cnt/ovf out)
module seq_scan_ctrl
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned OVERLAP = 1
) (
  input  logic           clk,
  input  logic           rst,
  seq_scan_ctrl_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  scan_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic             ovf_run_q, ovf_run_d, ovf_run_inc;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             det_q, det_clr, det_en, bit_out, hit_w, cnt_sat;

  seq_det_101 #(.OVERLAP(OVERLAP)) u_det (
    .clk (clk),
    .rst (rst),
    .clr (det_clr),
    .en  (det_en),
    .i   (bit_out),
    .q   (det_q)
  );

  // Detector q lags the presented bit by one cycle: in the first SHIFT cycle
  // it still belongs to the previous word, and in DONE it carries the last bit.
  always_comb begin
    det_en      = (state_q == ST_SHIFT);
    det_clr     = (state_q == ST_IDLE) && bus.in_valid && !bus.in_chain;
    bit_out     = (state_q == ST_SHIFT) && shreg_q[WIDTH-1];
    hit_w       = det_q && (((state_q == ST_SHIFT) && (idx_q != '0)) ||
                            (state_q == ST_DONE));
    cnt_sat     = &cnt_q;
    cnt_inc     = (hit_w && !cnt_sat) ? cnt_q + CNT_W'(1) : cnt_q;
    ovf_run_inc = ovf_run_q || (hit_w && cnt_sat);
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ovf_run_d   = ovf_run_q;
    match_cnt_d = match_cnt_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          shreg_d   = bus.in_data;
          idx_d     = '0;
          cnt_d     = '0;
          ovf_run_d = 1'b0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = shreg_q << 1;
        idx_d     = idx_q + IDX_W'(1);
        cnt_d     = cnt_inc;
        ovf_run_d = ovf_run_inc;
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        match_cnt_d = cnt_inc;
        ovf_d       = ovf_run_inc;
        done_d      = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      ovf_run_q   <= 1'b0;
      match_cnt_q <= '0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      ovf_run_q   <= ovf_run_d;
      match_cnt_q <= match_cnt_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.bit_out   = bit_out;
  assign bus.hit       = hit_w;
  assign bus.done      = done_q;
  assign bus.match_cnt = match_cnt_q;
  assign bus.ovf       = ovf_q;

endmodule
